// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller: load-use, EX redirect and multi-cycle MD unit.
// Optional HAZ_STATS_EN adds saturating stall/flush statistics counters.
module hazard_ctrl #(
    parameter int unsigned MD_LATENCY = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_id_ex,
    input  logic [4:0] wr_num_id_ex,
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       uses_rt_id,
    input  logic       md_start_id,
    input  logic       md_dep_id,
    input  logic       redirect_ex,
    output logic       stall,
    output logic       flush_id_ex,
    output logic       flush_if_id,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0] stat_lu_stalls,
    output logic [15:0] stat_md_stalls,
    output logic [15:0] stat_flushes
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic [CNT_W-1:0] w_md_cnt_nxt;

    logic w_lu_hz;
    logic w_md_hz;
    logic w_busy;
    logic w_cnt_last;
    logic w_stall;
    logic w_flush_id_ex;
    logic w_flush_if_id;
    logic w_issue;

    assign w_busy     = (r_state == MD_BUSY);
    assign w_cnt_last = (r_md_cnt == CNT_ONE);

    assign w_lu_hz = ld_id_ex & (wr_num_id_ex != 5'd0) &
                     ((wr_num_id_ex == rs_id) | (uses_rt_id & (wr_num_id_ex == rt_id)));

    // A lone mfhi/mflo is let through on the last busy cycle so it picks up the forwarded result.
    assign w_md_hz = w_busy & (md_start_id | md_dep_id) &
                     ~(w_cnt_last & md_dep_id & ~md_start_id);

    // Output priority: redirect kills the ID instruction, so it overrides any hazard stall.
    always_comb begin
        w_stall       = 1'b0;
        w_flush_id_ex = 1'b0;
        w_flush_if_id = 1'b0;
        if (!rst_n) begin
            w_stall       = 1'b0;
            w_flush_id_ex = 1'b0;
            w_flush_if_id = 1'b0;
        end else if (redirect_ex) begin
            w_stall       = 1'b0;
            w_flush_id_ex = 1'b1;
            w_flush_if_id = 1'b1;
        end else if (w_lu_hz | w_md_hz) begin
            w_stall       = 1'b1;
            w_flush_id_ex = 1'b1;
            w_flush_if_id = 1'b0;
        end else begin
            w_stall       = 1'b0;
            w_flush_id_ex = 1'b0;
            w_flush_if_id = 1'b0;
        end
    end

    assign stall       = w_stall;
    assign flush_id_ex = w_flush_id_ex;
    assign flush_if_id = w_flush_if_id;
    assign md_busy     = rst_n & w_busy;
    assign md_done     = rst_n & w_busy & w_cnt_last;

    // The mult/div only counts as issued when it actually advances into EX.
    assign w_issue = md_start_id & ~w_stall & ~redirect_ex;

    // Next-state and busy-counter update; redirects never cancel an operation already in EX.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        case (r_state)
            RUN: begin
                if (w_issue) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = CNT_RELOAD;
                end else begin
                    w_state_nxt  = RUN;
                    w_md_cnt_nxt = CNT_ZERO;
                end
            end
            MD_BUSY: begin
                if (w_cnt_last) begin
                    if (w_issue) begin
                        w_state_nxt  = MD_BUSY;
                        w_md_cnt_nxt = CNT_RELOAD;
                    end else begin
                        w_state_nxt  = RUN;
                        w_md_cnt_nxt = CNT_ZERO;
                    end
                end else if (r_md_cnt != CNT_ZERO) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = r_md_cnt - CNT_ONE;
                end else begin
                    w_state_nxt  = RUN;
                    w_md_cnt_nxt = CNT_ZERO;
                end
            end
            default: begin
                w_state_nxt  = RUN;
                w_md_cnt_nxt = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_md_cnt <= CNT_ZERO;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

`ifdef HAZ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic en);
        logic [15:0] res;
        if (en && (val != 16'hFFFF)) begin
            res = val + 16'd1;
        end else begin
            res = val;
        end
        return res;
    endfunction

    logic [15:0] r_stat_lu;
    logic [15:0] r_stat_md;
    logic [15:0] r_stat_fl;

    // Saturating event counters; a cycle with both hazards counts in both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_lu <= 16'd0;
            r_stat_md <= 16'd0;
            r_stat_fl <= 16'd0;
        end else begin
            r_stat_lu <= sat_inc(r_stat_lu, w_stall & w_lu_hz);
            r_stat_md <= sat_inc(r_stat_md, w_stall & w_md_hz);
            r_stat_fl <= sat_inc(r_stat_fl, w_flush_if_id);
        end
    end

    assign stat_lu_stalls = r_stat_lu;
    assign stat_md_stalls = r_stat_md;
    assign stat_flushes   = r_stat_fl;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the ID/EX pipeline register and the front end.
- Generates `stall` (hold PC and IF/ID, inject bubble) and `flush` (squash into ID/EX, squash IF/ID) from three sources:
  - load-use hazards,
  - taken-branch/jump redirects resolved in EX,
  - a multi-cycle multiply/divide unit.
- Sits beside the decode stage; its outputs drive the existing `stall`/`flush` inputs of id_ex and if_id.

Parameters:
- MD_LATENCY, 4, EX cycles a mult/div occupies the MD unit (legal range 2..15).
- CNT_W, 4, width of the MD busy counter; must satisfy 2**CNT_W > MD_LATENCY.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ld_id_ex  input  1  instruction in EX is a load
- wr_num_id_ex  input  5  destination register of instruction in EX
- rs_id  input  5  rs field of instruction in ID
- rt_id  input  5  rt field of instruction in ID
- uses_rt_id  input  1  instruction in ID reads rt as a source
- md_start_id  input  1  instruction in ID is mult/div
- md_dep_id  input  1  instruction in ID reads HI/LO (mfhi/mflo)
- redirect_ex  input  1  branch/jump in EX taken; PC is being redirected
- stall  output  1  hold PC and IF/ID this cycle
- flush_id_ex  output  1  load a bubble into ID/EX at next edge
- flush_if_id  output  1  squash IF/ID at next edge
- md_busy  output  1  MD unit occupied
- md_done  output  1  one-cycle pulse on the last MD cycle

Behaviour:
- States: RUN, MD_BUSY. Register `md_cnt` is CNT_W bits wide.
- Reset (rst_n=0, asynchronous):
  - state=RUN, md_cnt=0, md_done=0.
  - stall, flush_id_ex, flush_if_id and md_busy are forced 0 while rst_n=0.
- lu_hz (combinational) = ld_id_ex & (wr_num_id_ex!=0) & ((wr_num_id_ex==rs_id) | (uses_rt_id & wr_num_id_ex==rt_id)).
- md_hz (combinational) = (state==MD_BUSY) & (md_start_id | md_dep_id) & !(md_cnt==1 & md_dep_id & !md_start_id).
  - The final busy cycle releases a waiting mfhi/mflo one cycle early, so the result is forwarded on the next cycle.
  - A back-to-back mult/div still waits for the full drain.
- Output priority, same cycle (all combinational, zero latency):
  1. redirect_ex=1: flush_if_id=1, flush_id_ex=1, stall=0. The redirect overrides all hazards, since the younger ID instruction is dead.
  2. Otherwise lu_hz | md_hz: stall=1, flush_id_ex=1, flush_if_id=0.
  3. Otherwise all three outputs are 0.
- RUN -> MD_BUSY:
  - Taken at the clock edge where md_start_id=1, stall=0 and redirect_ex=0, i.e. the mult/div actually moves into EX.
  - md_cnt loads MD_LATENCY-1.
- In MD_BUSY, md_cnt decrements each cycle.
  - When md_cnt==1: md_done=1 for that cycle; next state=RUN and md_cnt=0.
  - If md_start_id=1 and is not stalled on that same edge, the FSM re-enters MD_BUSY with md_cnt=MD_LATENCY-1 (back-to-back issue). This only occurs once md_hz has cleared.
- md_busy = (state==MD_BUSY).
- A redirect during MD_BUSY does not cancel the MD operation, because it is older than the branch. The counter continues.
- md_cnt never wraps: decrement happens only in MD_BUSY with md_cnt>=1.
- Reset mid-operation returns to RUN immediately. No md_done pulse is emitted.

Optional Feature:
- Macro HAZ_STATS_EN.
- When defined, adds three outputs, each 16 bits wide and saturating at 16'hFFFF:
  - stat_lu_stalls: increments each cycle stall=1 due to lu_hz.
  - stat_md_stalls: increments each cycle stall=1 due to md_hz.
  - stat_flushes: increments each cycle flush_if_id=1.
- All three counters are cleared by rst_n.
- When undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Load-use on rs: ld_id_ex=1, wr_num_id_ex=5, rs_id=5 for one cycle -> stall=1, flush_id_ex=1 that cycle. Then ld_id_ex=0 -> all outputs 0.
- $0 and uses_rt gating:
  - wr_num_id_ex=0=rs_id with ld_id_ex=1 -> no stall.
  - wr_num_id_ex=rt_id=7 with uses_rt_id=0 -> no stall.
  - Same case with uses_rt_id=1 -> stall=1.
- Redirect beats load-use: redirect_ex=1 with lu_hz=1 -> stall=0, flush_if_id=1, flush_id_ex=1.
- MD sequence with MD_LATENCY=4:
  - md_start_id=1 for one cycle -> md_busy=1 for 3 cycles, md_done=1 on the 3rd.
  - mfhi (md_dep_id=1) held in ID from the cycle after issue -> stall=1 for exactly 2 cycles, then released.
- Back-to-back mult while busy: md_start_id held high -> stall until md_cnt reaches 0. Second issue reloads md_cnt=3; md_done pulses once per operation.
- Reset mid-MD: assert rst_n=0 while md_cnt=2 -> state=RUN, md_busy=0, stall=0 immediately (asynchronous), no md_done pulse. With HAZ_STATS_EN, all stat counters read 0.
